// File: rtl/mem_arbiter_axi.sv
// Two-master (instruction / data) arbiter in front of the AXI memory-access translator.
// Define MEM_ARB_ROUND_ROBIN_EN for I/D class alternation instead of fixed priority with starvation guard.
module mem_arbiter_axi #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        I_RDEN,
  input  logic [31:0] I_RADDR,
  input  logic        I_STALL,
  output logic        I_RVALID,
  output logic [31:0] I_ROADDR,
  output logic [31:0] I_RDATA,
  input  logic        D_RDEN,
  input  logic [31:0] D_RADDR,
  input  logic        D_STALL,
  output logic        D_RVALID,
  output logic [31:0] D_ROADDR,
  output logic [31:0] D_RDATA,
  input  logic        D_WREN,
  input  logic [3:0]  D_WSTRB,
  input  logic [31:0] D_WADDR,
  input  logic [31:0] D_WDATA,
  output logic        D_WDONE,
  output logic        M_RSELECT,
  output logic        M_RDEN,
  output logic [31:0] M_RIADDR,
  input  logic [31:0] M_ROADDR,
  input  logic        M_RVALID,
  input  logic [31:0] M_RDATA,
  output logic        M_WSELECT,
  output logic        M_WREN,
  output logic [3:0]  M_WSTRB,
  output logic [31:0] M_WADDR,
  output logic [31:0] M_WDATA,
  output logic        M_STALL,
  input  logic        M_LOADING
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_RESP, S_WRITE} state_t;
  typedef enum logic {SRC_I = 1'b0, SRC_D = 1'b1} src_t;

  state_t      state, state_nx;
  src_t        src, src_nx;
  logic        rselect_nx, rden_nx, wselect_nx, wren_nx;
  logic [31:0] riaddr_nx, waddr_nx, wdata_nx;
  logic [3:0]  wstrb_nx;
  logic        grant_i, grant_dr, grant_dw;
  logic        d_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  src_t last_grant, last_grant_nx;
`else
  localparam logic [3:0] LIMIT = STARVE_LIMIT[3:0];
  logic [3:0] starve_cnt, starve_cnt_nx;
`endif

  // Arbitration: only consulted in S_IDLE; write always beats read inside the D class.
  always_comb begin
    d_req = D_WREN || D_RDEN;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    grant_i = I_RDEN && (!d_req || last_grant == SRC_D);
`else
    grant_i = I_RDEN && (!d_req || starve_cnt == LIMIT);
`endif
    grant_dw = !grant_i && D_WREN;
    grant_dr = !grant_i && !D_WREN && D_RDEN;
  end

`ifdef MEM_ARB_ROUND_ROBIN_EN
`else
  always_comb begin
    starve_cnt_nx = starve_cnt;
    if (!I_RDEN)
      starve_cnt_nx = '0;
    else if (state == S_IDLE && grant_i)
      starve_cnt_nx = '0;
    else if (state == S_IDLE && (grant_dr || grant_dw) && starve_cnt != LIMIT)
      starve_cnt_nx = starve_cnt + 4'd1;
  end
`endif

  always_comb begin
    M_STALL = 1'b0;
    if (state == S_RESP)
      M_STALL = (src == SRC_I) ? I_STALL : D_STALL;
  end

  always_comb begin
    I_RVALID = 1'b0;
    I_RDATA  = '0;
    I_ROADDR = '0;
    D_RVALID = 1'b0;
    D_RDATA  = '0;
    D_ROADDR = '0;
    if (state == S_RESP) begin
      if (src == SRC_I) begin
        I_RVALID = M_RVALID;
        I_RDATA  = M_RDATA;
        I_ROADDR = M_ROADDR;
      end else begin
        D_RVALID = M_RVALID;
        D_RDATA  = M_RDATA;
        D_ROADDR = M_ROADDR;
      end
    end
  end

  assign D_WDONE = (state == S_WRITE) && !M_LOADING;

  always_comb begin
    state_nx   = state;
    src_nx     = src;
    rselect_nx = M_RSELECT;
    rden_nx    = M_RDEN;
    riaddr_nx  = M_RIADDR;
    wselect_nx = M_WSELECT;
    wren_nx    = M_WREN;
    wstrb_nx   = M_WSTRB;
    waddr_nx   = M_WADDR;
    wdata_nx   = M_WDATA;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_grant_nx = last_grant;
`endif
    case (state)
      S_IDLE: begin
        if (grant_i || grant_dr) begin
          state_nx   = S_READ;
          src_nx     = grant_i ? SRC_I : SRC_D;
          riaddr_nx  = grant_i ? I_RADDR : D_RADDR;
          rselect_nx = 1'b1;
          rden_nx    = 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_grant_nx = grant_i ? SRC_I : SRC_D;
`endif
        end else if (grant_dw) begin
          state_nx   = S_WRITE;
          src_nx     = SRC_D;
          waddr_nx   = D_WADDR;
          wdata_nx   = D_WDATA;
          wstrb_nx   = D_WSTRB;
          wselect_nx = 1'b1;
          wren_nx    = 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_grant_nx = SRC_D;
`endif
        end
      end
      S_READ: begin
        if (!M_LOADING) begin
          state_nx = S_RESP;
          rden_nx  = 1'b0;
        end
      end
      // Select stays up while the response is pending so the translator keeps routing it here.
      S_RESP: begin
        if (M_RVALID && !M_STALL) begin
          state_nx   = S_IDLE;
          rselect_nx = 1'b0;
        end
      end
      S_WRITE: begin
        if (!M_LOADING) begin
          state_nx   = S_IDLE;
          wselect_nx = 1'b0;
          wren_nx    = 1'b0;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= S_IDLE;
      src       <= SRC_I;
      M_RSELECT <= 1'b0;
      M_RDEN    <= 1'b0;
      M_RIADDR  <= '0;
      M_WSELECT <= 1'b0;
      M_WREN    <= 1'b0;
      M_WSTRB   <= '0;
      M_WADDR   <= '0;
      M_WDATA   <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_grant <= SRC_D;
`else
      starve_cnt <= '0;
`endif
    end else begin
      state     <= state_nx;
      src       <= src_nx;
      M_RSELECT <= rselect_nx;
      M_RDEN    <= rden_nx;
      M_RIADDR  <= riaddr_nx;
      M_WSELECT <= wselect_nx;
      M_WREN    <= wren_nx;
      M_WSTRB   <= wstrb_nx;
      M_WADDR   <= waddr_nx;
      M_WDATA   <= wdata_nx;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_grant <= last_grant_nx;
`else
      starve_cnt <= starve_cnt_nx;
`endif
    end
  end

endmodule

// File: tb/tb_mem_arbiter_axi.sv
// Directed bench for mem_arbiter_axi: per-cycle vector table plus hand-written multi-cycle sequences.
module tb_mem_arbiter_axi;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        I_RDEN, I_STALL, I_RVALID;
  logic [31:0] I_RADDR, I_ROADDR, I_RDATA;
  logic        D_RDEN, D_STALL, D_RVALID, D_WREN, D_WDONE;
  logic [31:0] D_RADDR, D_ROADDR, D_RDATA, D_WADDR, D_WDATA;
  logic [3:0]  D_WSTRB;
  logic        M_RSELECT, M_RDEN, M_RVALID, M_WSELECT, M_WREN, M_STALL, M_LOADING;
  logic [31:0] M_RIADDR, M_ROADDR, M_RDATA, M_WADDR, M_WDATA;
  logic [3:0]  M_WSTRB;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  mem_arbiter_axi #(.STARVE_LIMIT(4)) dut (
    .CLK(CLK), .RST(RST),
    .I_RDEN(I_RDEN), .I_RADDR(I_RADDR), .I_STALL(I_STALL),
    .I_RVALID(I_RVALID), .I_ROADDR(I_ROADDR), .I_RDATA(I_RDATA),
    .D_RDEN(D_RDEN), .D_RADDR(D_RADDR), .D_STALL(D_STALL),
    .D_RVALID(D_RVALID), .D_ROADDR(D_ROADDR), .D_RDATA(D_RDATA),
    .D_WREN(D_WREN), .D_WSTRB(D_WSTRB), .D_WADDR(D_WADDR), .D_WDATA(D_WDATA),
    .D_WDONE(D_WDONE),
    .M_RSELECT(M_RSELECT), .M_RDEN(M_RDEN), .M_RIADDR(M_RIADDR),
    .M_ROADDR(M_ROADDR), .M_RVALID(M_RVALID), .M_RDATA(M_RDATA),
    .M_WSELECT(M_WSELECT), .M_WREN(M_WREN), .M_WSTRB(M_WSTRB),
    .M_WADDR(M_WADDR), .M_WDATA(M_WDATA), .M_STALL(M_STALL),
    .M_LOADING(M_LOADING)
  );

  // in_bits  = {I_RDEN, D_RDEN, D_WREN, M_LOADING, M_RVALID, I_STALL, D_STALL}
  // exp_bits = {M_RDEN, M_WREN, D_WDONE, M_STALL, I_RVALID, D_RVALID}
  typedef struct {
    logic [6:0]  in_bits;
    logic [31:0] rdata;
    logic [31:0] roaddr;
    logic [5:0]  exp_bits;
    logic [31:0] e_ird, e_ira, e_drd, e_dra;
  } vec_t;

  vec_t        tbl[15];
  logic [31:0] grant_exp[6];

  function automatic vec_t v(input logic [6:0] ib, input logic [31:0] rd, input logic [31:0] ra,
                             input logic [5:0] eb, input logic [31:0] ird, input logic [31:0] ira,
                             input logic [31:0] drd, input logic [31:0] dra);
    vec_t r;
    r.in_bits = ib; r.rdata = rd; r.roaddr = ra; r.exp_bits = eb;
    r.e_ird = ird; r.e_ira = ira; r.e_drd = drd; r.e_dra = dra;
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Translator-side monitor: records accepted read addresses and write transactions.
  logic [31:0] rd_q[$];
  int          wr_cnt = 0;
  logic [31:0] cap_waddr = '0;
  logic [31:0] cap_wdata = '0;
  logic [3:0]  cap_wstrb = '0;

  always @(negedge CLK) begin
    if (!RST) begin
      if (M_RDEN && !M_LOADING) rd_q.push_back(M_RIADDR);
      if (M_WREN && !M_LOADING) begin
        wr_cnt++;
        cap_waddr = M_WADDR;
        cap_wdata = M_WDATA;
        cap_wstrb = M_WSTRB;
      end
    end
  end

  // Waits for a read grant, completes it with an immediate response, returns the granted address.
  task automatic serve_read(output logic [31:0] a, output bit ok);
    ok = 1'b0;
    a  = '0;
    for (int k = 0; k < 20; k++) begin
      if (M_RDEN) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (ok) begin
      a = M_RIADDR;
      step();
      M_RVALID = 1'b1;
      step();
      M_RVALID = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    bit          ok;

    I_RDEN = 0; I_STALL = 0; D_RDEN = 0; D_STALL = 0; D_WREN = 0;
    M_RVALID = 0; M_LOADING = 0; M_RDATA = '0; M_ROADDR = '0;
    I_RADDR = 32'h100; D_RADDR = 32'h204;
    D_WADDR = 32'h200; D_WDATA = 32'h1122_3344; D_WSTRB = 4'hF;

    // I read with translator busy, then write+read collision, then D read with consumer stall.
    tbl[0]  = v(7'b1001000, 32'hDEADBEEF, 32'h100, 6'b000000, 0, 0, 0, 0);
    tbl[1]  = v(7'b1001000, 32'hDEADBEEF, 32'h100, 6'b100000, 0, 0, 0, 0);
    tbl[2]  = v(7'b1001000, 32'hDEADBEEF, 32'h100, 6'b100000, 0, 0, 0, 0);
    tbl[3]  = v(7'b1000000, 32'hDEADBEEF, 32'h100, 6'b100000, 0, 0, 0, 0);
    tbl[4]  = v(7'b1000100, 32'hDEADBEEF, 32'h100, 6'b000010, 32'hDEADBEEF, 32'h100, 0, 0);
    tbl[5]  = v(7'b0000000, 32'hDEADBEEF, 32'h100, 6'b000000, 0, 0, 0, 0);
    tbl[6]  = v(7'b0110000, 32'hCAFEF00D, 32'h204, 6'b000000, 0, 0, 0, 0);
    tbl[7]  = v(7'b0111000, 32'hCAFEF00D, 32'h204, 6'b010000, 0, 0, 0, 0);
    tbl[8]  = v(7'b0110000, 32'hCAFEF00D, 32'h204, 6'b011000, 0, 0, 0, 0);
    tbl[9]  = v(7'b0100000, 32'hCAFEF00D, 32'h204, 6'b000000, 0, 0, 0, 0);
    tbl[10] = v(7'b0100000, 32'hCAFEF00D, 32'h204, 6'b100000, 0, 0, 0, 0);
    tbl[11] = v(7'b0100101, 32'hCAFEF00D, 32'h204, 6'b000101, 0, 0, 32'hCAFEF00D, 32'h204);
    tbl[12] = v(7'b0100101, 32'hCAFEF00D, 32'h204, 6'b000101, 0, 0, 32'hCAFEF00D, 32'h204);
    tbl[13] = v(7'b0100110, 32'hCAFEF00D, 32'h204, 6'b000001, 0, 0, 32'hCAFEF00D, 32'h204);
    tbl[14] = v(7'b0000000, 32'hCAFEF00D, 32'h204, 6'b000000, 0, 0, 0, 0);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    grant_exp[0] = 32'h204; grant_exp[1] = 32'h100; grant_exp[2] = 32'h204;
    grant_exp[3] = 32'h100; grant_exp[4] = 32'h204; grant_exp[5] = 32'h100;
`else
    grant_exp[0] = 32'h204; grant_exp[1] = 32'h204; grant_exp[2] = 32'h204;
    grant_exp[3] = 32'h204; grant_exp[4] = 32'h100; grant_exp[5] = 32'h204;
`endif

    repeat (3) @(posedge CLK);
    #1;
    check("reset_ctrl", 128'({M_RSELECT, M_RDEN, M_WSELECT, M_WREN, M_STALL, M_WSTRB}), '0);
    check("reset_bus", 128'({M_RIADDR, M_WADDR, M_WDATA}), '0);
    check("reset_resp", 128'({I_RVALID, D_RVALID, D_WDONE}), '0);
    RST = 1'b0;
    step();
    step();

    for (int i = 0; i < 15; i++) begin
      {I_RDEN, D_RDEN, D_WREN, M_LOADING, M_RVALID, I_STALL, D_STALL} = tbl[i].in_bits;
      M_RDATA  = tbl[i].rdata;
      M_ROADDR = tbl[i].roaddr;
      #2;
      check($sformatf("row%0d_ctrl", i),
            128'({M_RDEN, M_WREN, D_WDONE, M_STALL, I_RVALID, D_RVALID}), 128'(tbl[i].exp_bits));
      check($sformatf("row%0d_data", i), {I_RDATA, I_ROADDR, D_RDATA, D_ROADDR},
            {tbl[i].e_ird, tbl[i].e_ira, tbl[i].e_drd, tbl[i].e_dra});
      step();
    end

    check("read_accepts", 128'(rd_q.size()), 128'(2));
    if (rd_q.size() == 2) check("read_order", 128'({rd_q[0], rd_q[1]}), 128'({32'h100, 32'h204}));
    check("write_count", 128'(wr_cnt), 128'(1));
    check("write_payload", 128'({cap_waddr, cap_wdata, cap_wstrb}),
          128'({32'h200, 32'h1122_3344, 4'hF}));

    // Arbitration sequence: starvation guard (fixed) or class alternation (round robin).
    M_RDATA = 32'h55AA55AA;
    M_ROADDR = '0;
    D_RDEN = 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    I_RDEN = 1'b0;
`else
    I_RDEN = 1'b1;
`endif
    for (int g = 0; g < 6; g++) begin
      serve_read(a, ok);
      if (!ok) begin
        checks++;
        errors++;
        $display("FAIL grant%0d_timeout: got no M_RDEN expected grant within 20 cycles", g);
      end else begin
        check($sformatf("grant%0d", g), 128'(a), 128'(grant_exp[g]));
      end
      I_RDEN = 1'b1;
    end
    I_RDEN = 1'b0;
    D_RDEN = 1'b0;
    step();
    step();

    // Reset while a read is outstanding, then the still-held I request must be granted again.
    I_RDEN = 1'b1;
    M_LOADING = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (M_RDEN) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL rst_setup_timeout: got no M_RDEN expected grant within 20 cycles");
    end
    #2;
    RST = 1'b1;
    #1;
    check("rst_async_ctrl", 128'({M_RSELECT, M_RDEN, M_WSELECT, M_WREN, M_STALL, M_WSTRB}), '0);
    check("rst_async_bus", 128'({M_RIADDR, M_WADDR, M_WDATA}), '0);
    step();
    step();
    RST = 1'b0;
    M_LOADING = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (M_RDEN) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL rst_regrant_timeout: got no M_RDEN expected grant within 20 cycles");
    end else begin
      check("rst_regrant_addr", 128'(M_RIADDR), 128'(32'h100));
      step();
      M_RVALID = 1'b1;
      M_RDATA = 32'h0BADF00D;
      M_ROADDR = 32'h100;
      #1;
      check("rst_regrant_resp", 128'({I_RVALID, D_RVALID, I_RDATA, I_ROADDR}),
            128'({1'b1, 1'b0, 32'h0BADF00D, 32'h100}));
      step();
      M_RVALID = 1'b0;
      I_RDEN = 1'b0;
    end
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
